// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared constants, state encoding and song table for the music sequencer
package music_pkg;

    localparam int NSONG  = 4;
    localparam int ROM_AW = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_PLAY  = 3'd2,
        S_GAP   = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    // Inclusive address range of each song in the note ROM; song 0 is the original tune.
    localparam logic [ROM_AW-1:0] SONG_START [NSONG] = '{8'd0,   8'd138, 8'd180, 8'd220};
    localparam logic [ROM_AW-1:0] SONG_END   [NSONG] = '{8'd137, 8'd179, 8'd219, 8'd255};

endpackage

// File: rtl/music_seq_gap_timer.sv
// rtl/music_seq_gap_timer.sv - load/count/expire down-counter for the articulation gap
// Ports: clk, rst_n (async active-low), load (preset to GAP_CYC-1),
//        en (count while high), expire (en and counter at zero).
module gap_timer #(
    parameter int GAP_CYC = 4096,
    localparam int CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(GAP_CYC - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Loaded with GAP_CYC-1 so that the muted window is exactly GAP_CYC cycles.
    assign expire = en && (cnt == '0);

endmodule

// File: rtl/music_seq_ctrl.sv
// rtl/music_seq_ctrl.sv - playback sequencer: ROM address stepping, play/pause/stop/next, note articulation
// Ports: clk, rst_n (async active-low); tick tempo strobe; btn_play/btn_stop/btn_next
//        1-cycle button pulses; loop_en level; rom_addr/rom_q synchronous ROM port;
//        note_idx to f_code (0 = silent); playing, song_sel, step, song_done status.
module music_seq_ctrl
    import music_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 4,
    parameter int NSONG   = music_pkg::NSONG,
    parameter int GAP_CYC = 4096,
    parameter int ART_EN  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          btn_play,
    input  logic          btn_stop,
    input  logic          btn_next,
    input  logic          loop_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic [DW-1:0] note_idx,
    output logic          playing,
    output logic [1:0]    song_sel,
    output logic [AW-1:0] step,
    output logic          song_done
);

    state_t        state, state_n;
    logic [AW-1:0] addr_n, step_n;
    logic [1:0]    song_n, song_nx;
    logic [DW-1:0] note_n, prev, prev_n, held, held_n;
    logic          skip, skip_n;          // next fetch is a resume from pause: never gap
    logic          fetch_rdy, fetch_rdy_n; // rom_q reflects rom_addr from this cycle on
    logic          done_n, gap_load, gap_expire, repeat_note;

    assign song_nx     = (32'(song_sel) >= NSONG - 1) ? 2'd0 : song_sel + 2'd1;
    assign repeat_note = (ART_EN != 0) && (rom_q == prev) && (rom_q != '0) && !skip;

    gap_timer #(.GAP_CYC(GAP_CYC)) u_gap (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (gap_load),
        .en     (state == S_GAP),
        .expire (gap_expire)
    );

    always_comb begin
        state_n     = state;
        addr_n      = rom_addr;
        step_n      = step;
        song_n      = song_sel;
        note_n      = note_idx;
        prev_n      = prev;
        held_n      = held;
        skip_n      = skip;
        fetch_rdy_n = 1'b0;
        done_n      = 1'b0;
        gap_load    = 1'b0;

        if (btn_stop) begin
            state_n = S_IDLE;
            addr_n  = AW'(SONG_START[song_sel]);
            step_n  = '0;
            note_n  = '0;
            prev_n  = '0;
            skip_n  = 1'b0;
        end else if (btn_next) begin
            song_n  = song_nx;
            addr_n  = AW'(SONG_START[song_nx]);
            step_n  = '0;
            note_n  = '0;
            prev_n  = '0;
            skip_n  = 1'b0;
            state_n = (state == S_PLAY || state == S_GAP || state == S_FETCH) ? S_FETCH : S_IDLE;
        end else if (btn_play && state != S_FETCH) begin
            if (state == S_PLAY || state == S_GAP) begin
                state_n = S_PAUSE;
                note_n  = '0;
            end else begin
                state_n = S_FETCH;
                skip_n  = (state == S_PAUSE);
            end
        end else begin
            case (state)
                S_IDLE: begin
                    note_n = '0;
                    prev_n = '0;
                    skip_n = 1'b0;
                end
                S_FETCH: begin
                    if (!fetch_rdy) begin
                        fetch_rdy_n = 1'b1;
                    end else begin
                        prev_n = rom_q;
                        skip_n = 1'b0;
                        if (repeat_note) begin
                            note_n   = '0;
                            held_n   = rom_q;
                            gap_load = 1'b1;
                            state_n  = S_GAP;
                        end else begin
                            note_n  = rom_q;
                            state_n = S_PLAY;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_expire) begin
                        note_n  = held;
                        state_n = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        if (rom_addr == AW'(SONG_END[song_sel])) begin
                            addr_n = AW'(SONG_START[song_sel]);
                            step_n = '0;
                            prev_n = '0;
                            if (loop_en) begin
                                state_n = S_FETCH;
                            end else begin
                                state_n = S_IDLE;
                                note_n  = '0;
                                done_n  = 1'b1;
                            end
                        end else begin
                            addr_n  = rom_addr + 1'b1;
                            step_n  = step + 1'b1;
                            state_n = S_FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rom_addr  <= AW'(SONG_START[0]);
            step      <= '0;
            song_sel  <= 2'd0;
            note_idx  <= '0;
            prev      <= '0;
            held      <= '0;
            skip      <= 1'b0;
            fetch_rdy <= 1'b0;
            song_done <= 1'b0;
        end else begin
            state     <= state_n;
            rom_addr  <= addr_n;
            step      <= step_n;
            song_sel  <= song_n;
            note_idx  <= note_n;
            prev      <= prev_n;
            held      <= held_n;
            skip      <= skip_n;
            fetch_rdy <= fetch_rdy_n;
            song_done <= done_n;
        end
    end

    assign playing = (state == S_PLAY) || (state == S_GAP);

endmodule
